// File: rtl/game_pkg.sv
// Shared game definitions: state bus encoding and winner codes.
// Used by the race sequencer and by both player physics engines.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTING   = 3'd1,
        COUNTDOWN = 3'd3,
        RACING    = 3'd4,
        PAUSE     = 3'd5,
        FINISH    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        TIE  = 2'd3
    } winner_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/race_state_controller_if.sv
// Button/engine inputs and game status outputs of the race sequencer.
interface race_state_controller_if;

    logic        start_btn;
    logic        pause_btn;
    logic        p1_ready;
    logic        p2_ready;
    logic        p1_finish;
    logic        p2_finish;
    logic [2:0]  state;
    logic [1:0]  countdown;
    logic [15:0] race_time;
    logic [1:0]  winner;
    logic        race_active;

    modport master (
        output start_btn, pause_btn, p1_ready, p2_ready, p1_finish, p2_finish,
        input  state, countdown, race_time, winner, race_active
    );

    modport slave (
        input  start_btn, pause_btn, p1_ready, p2_ready, p1_finish, p2_finish,
        output state, countdown, race_time, winner, race_active
    );

endinterface

// File: rtl/edge_detect.sv
// One-cycle rising-edge pulse for a debounced button level.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic btn_d;

    // NOTE: history resets to 1 so a button held through reset is not seen as a press;
    // non-blocking so every flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_d <= 1'b1;
        end else begin
            btn_d <= btn;
        end
    end

    assign pulse = btn & ~btn_d;

endmodule

// File: rtl/race_state_controller.sv
// Game sequencer: drives the shared state bus, runs the start countdown,
// keeps the race timer in tenths of a second and latches the winner.
module race_state_controller
    import game_pkg::*;
#(
    parameter int          CLK_FREQ   = 100_000_000,
    parameter int          COUNT_FROM = 3,
    parameter logic [15:0] TIME_MAX   = 16'hFFFF
) (
    input logic                   clk,
    input logic                   rst_n,
    race_state_controller_if.slave bus
);

    localparam int SEC_W   = cnt_width(CLK_FREQ);
    localparam int TENTH_W = cnt_width(CLK_FREQ / 10);
    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(CLK_FREQ - 1);
    localparam logic [TENTH_W-1:0] TENTH_LAST = TENTH_W'(CLK_FREQ / 10 - 1);

    logic start_edge;
    logic pause_edge;

    edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .btn(bus.start_btn), .pulse(start_edge));
    edge_detect u_pause_edge (.clk(clk), .rst_n(rst_n), .btn(bus.pause_btn), .pulse(pause_edge));

    state_t               state_q;
    logic [1:0]           countdown_q;
    logic [15:0]          race_time_q;
    winner_t              winner_q;
    logic                 race_active_q;
    logic [SEC_W-1:0]     sec_cnt;
    logic [TENTH_W-1:0]   tenth_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            countdown_q   <= 2'd0;
            race_time_q   <= 16'd0;
            winner_q      <= NONE;
            race_active_q <= 1'b0;
            sec_cnt       <= '0;
            tenth_cnt     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    countdown_q <= 2'd0;
                    sec_cnt     <= '0;
                    tenth_cnt   <= '0;
                    if (start_edge) state_q <= SETTING;
                end
                SETTING: begin
                    if (bus.p1_ready && bus.p2_ready) begin
                        state_q     <= COUNTDOWN;
                        countdown_q <= 2'(COUNT_FROM);
                        sec_cnt     <= '0;
                        tenth_cnt   <= '0;
                        race_time_q <= 16'd0;
                        winner_q    <= NONE;
                    end
                end
                COUNTDOWN: begin
                    if (sec_cnt == SEC_LAST) begin
                        sec_cnt <= '0;
                        if (countdown_q == 2'd1) begin
                            state_q       <= RACING;
                            countdown_q   <= 2'd0;
                            race_active_q <= 1'b1;
                        end else begin
                            countdown_q <= countdown_q - 2'd1;
                        end
                    end else begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                RACING: begin
                    // A finish in the same cycle as a pause press takes priority.
                    if (bus.p1_finish || bus.p2_finish) begin
                        state_q       <= FINISH;
                        winner_q      <= winner_t'({bus.p2_finish, bus.p1_finish});
                        race_active_q <= 1'b0;
                    end else if (pause_edge) begin
                        state_q       <= PAUSE;
                        race_active_q <= 1'b0;
                    end else if (tenth_cnt == TENTH_LAST) begin
                        tenth_cnt <= '0;
                        if (race_time_q < TIME_MAX) race_time_q <= race_time_q + 16'd1;
                    end else begin
                        tenth_cnt <= tenth_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start_edge) begin
                        state_q <= IDLE;
                    end else if (pause_edge) begin
                        state_q       <= RACING;
                        race_active_q <= 1'b1;
                    end
                end
                FINISH: begin
                    if (start_edge) state_q <= IDLE;
                end
                default: begin
                    state_q       <= IDLE;
                    countdown_q   <= 2'd0;
                    race_active_q <= 1'b0;
                    sec_cnt       <= '0;
                    tenth_cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.countdown   = countdown_q;
    assign bus.race_time   = race_time_q;
    assign bus.winner      = winner_q;
    assign bus.race_active = race_active_q;

endmodule

// File: tb/tb_race_state_controller.sv
// Scoreboard bench for race_state_controller: a cycle-count reference model
// predicts every post-edge output word; a monitor compares after each edge.
module tb_race_state_controller;
    import game_pkg::*;

    localparam int CF    = 100;
    localparam int CFROM = 3;
    localparam int TMAX  = 30;
    localparam int TENTH = CF / 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    race_state_controller_if bus();

    race_state_controller #(
        .CLK_FREQ  (CF),
        .COUNT_FROM(CFROM),
        .TIME_MAX  (16'(TMAX))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: phases tracked by elapsed cycle counts, not counters.
    state_t     m_state;
    int         m_cd_cycles;
    int         m_race_cycles;
    int         m_cd_digit;
    logic [1:0] m_win;
    logic       m_sprev;
    logic       m_pprev;

    function automatic logic [23:0] dut_out();
        return {bus.state, bus.countdown, bus.race_time, bus.winner, bus.race_active};
    endfunction

    function automatic int model_time();
        int rt;
        rt = m_race_cycles / TENTH;
        return (rt > TMAX) ? TMAX : rt;
    endfunction

    function automatic logic [23:0] model_out();
        int rt;
        int cd;
        rt = model_time();
        cd = m_cd_digit;
        return {3'(m_state), cd[1:0], rt[15:0], m_win, (m_state == RACING)};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: dut st=%0d cd=%0d time=%0d win=%0d act=%0b, want st=%0d cd=%0d time=%0d win=%0d act=%0b",
                     name, $time, act[23:21], act[20:19], act[18:3], act[2:1], act[0],
                     exp[23:21], exp[20:19], exp[18:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic model_reset();
        m_state       = IDLE;
        m_cd_cycles   = 0;
        m_race_cycles = 0;
        m_cd_digit    = 0;
        m_win         = 2'd0;
        m_sprev       = 1'b1;
        m_pprev       = 1'b1;
    endtask

    task automatic model_step();
        logic se;
        logic pe;
        se      = bus.start_btn & ~m_sprev;
        pe      = bus.pause_btn & ~m_pprev;
        m_sprev = bus.start_btn;
        m_pprev = bus.pause_btn;
        case (m_state)
            IDLE: begin
                m_cd_digit = 0;
                if (se) m_state = SETTING;
            end
            SETTING: begin
                if (bus.p1_ready && bus.p2_ready) begin
                    m_state       = COUNTDOWN;
                    m_cd_cycles   = 0;
                    m_race_cycles = 0;
                    m_win         = 2'd0;
                    m_cd_digit    = CFROM;
                end
            end
            COUNTDOWN: begin
                m_cd_cycles++;
                if (m_cd_cycles == CFROM * CF) begin
                    m_state    = RACING;
                    m_cd_digit = 0;
                end else begin
                    m_cd_digit = CFROM - m_cd_cycles / CF;
                end
            end
            RACING: begin
                if (bus.p1_finish || bus.p2_finish) begin
                    m_state = FINISH;
                    m_win   = {bus.p2_finish, bus.p1_finish};
                end else if (pe) begin
                    m_state = PAUSE;
                end else begin
                    m_race_cycles++;
                end
            end
            PAUSE: begin
                if (se) m_state = IDLE;
                else if (pe) m_state = RACING;
            end
            FINISH: begin
                if (se) m_state = IDLE;
            end
            default: m_state = IDLE;
        endcase
    endtask

    // Inputs are applied at a falling edge; this predicts the next rising edge.
    task automatic tick(input string tag);
        exp_t e;
        model_step();
        e.v   = model_out();
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1 check(tag, dut_out(), 24'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, dut_out(), e.v);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, %0d vectors applied", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.start_btn = 1'b1;
        bus.pause_btn = 1'b0;
        bus.p1_ready  = 1'b0;
        bus.p2_ready  = 1'b0;
        bus.p1_finish = 1'b0;
        bus.p2_finish = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_out(), 24'd0);
        model_reset();
        rst_n = 1'b1;

        // Button held through reset must not register as a press.
        run(6, "start_held_through_reset");
        bus.start_btn = 1'b0;
        run(2, "start_release");
        bus.start_btn = 1'b1;
        run(1, "start_press_to_setting");
        bus.start_btn = 1'b0;
        run(3, "setting_hold");

        bus.p1_ready = 1'b1;
        run(5, "p1_ready_only");
        bus.p2_ready = 1'b1;
        run(1, "enter_countdown");
        for (int i = 0; i < CFROM * CF - 1; i++) begin
            bus.start_btn = 1'($urandom_range(0, 1));
            bus.pause_btn = 1'($urandom_range(0, 1));
            bus.p1_ready  = 1'($urandom_range(0, 1));
            tick("countdown_ignores_inputs");
        end
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        tick("countdown_to_racing");

        run(255, "racing");
        bus.pause_btn = 1'b1;
        run(1, "pause_enter");
        bus.pause_btn = 1'b0;
        run(500, "paused_frozen");
        bus.pause_btn = 1'b1;
        run(1, "pause_exit");
        bus.pause_btn = 1'b0;
        run(5, "resume_to_26");

        bus.p2_finish = 1'b1;
        bus.pause_btn = 1'b1;
        run(1, "finish_beats_pause");
        bus.p2_finish = 1'b0;
        bus.pause_btn = 1'b0;
        run(3, "finish_hold");
        bus.start_btn = 1'b1;
        run(1, "finish_to_idle");
        bus.start_btn = 1'b0;
        run(3, "idle_keeps_winner");

        bus.p1_ready  = 1'b1;
        bus.p2_ready  = 1'b1;
        bus.start_btn = 1'b1;
        run(1, "idle_to_setting");
        bus.start_btn = 1'b0;
        run(1, "setting_to_countdown");
        run(CFROM * CF, "countdown2");
        run(20 + int'($urandom_range(0, 60)), "race2");
        bus.p1_finish = 1'b1;
        bus.p2_finish = 1'b1;
        run(1, "tie_finish");
        bus.p1_finish = 1'b0;
        bus.p2_finish = 1'b0;
        run(2, "tie_hold");
        bus.start_btn = 1'b1;
        run(1, "tie_to_idle");
        bus.start_btn = 1'b0;
        run(1, "idle_keeps_tie");
        bus.start_btn = 1'b1;
        run(1, "idle_to_setting2");
        bus.start_btn = 1'b0;
        run(2, "countdown_clears_result");

        run(CFROM * CF, "countdown3");
        run(TMAX * TENTH + 60, "saturate");
        async_reset_check("async_reset_mid_race");

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.start_btn = ~bus.start_btn;
            if ($urandom_range(0, 29) == 0) bus.pause_btn = ~bus.pause_btn;
            if ($urandom_range(0, 59) == 0) bus.p1_ready = ~bus.p1_ready;
            if ($urandom_range(0, 59) == 0) bus.p2_ready = ~bus.p2_ready;
            bus.p1_finish = ($urandom_range(0, 299) == 0);
            bus.p2_finish = ($urandom_range(0, 299) == 0);
            tick("random");
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
